// File: rtl/ifft_pkg.sv
// Shared constants and FSM state type for the 4-point IFFT output stage.
package ifft_pkg;
  localparam int DATA_W = 16;
  localparam int N_PTS  = 4;
  localparam int IDX_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/ifft_round_sat.sv
// Round-half-up scaling by SHIFT followed by saturation to DATA_W signed bits.
module ifft_round_sat #(
  parameter int DATA_W = 16,
  parameter int SHIFT  = 2
) (
  input  logic signed [DATA_W:0]   x,
  output logic signed [DATA_W-1:0] y
);
  // Two guard bits so the rounding add never wraps before the clamp.
  localparam int EXT_W = DATA_W + 2;
  localparam int RND_I = (1 << SHIFT) >> 1;
  localparam logic signed [EXT_W-1:0] RND     = EXT_W'(RND_I);
  localparam logic signed [EXT_W-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};

  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] shifted;

  // round, arithmetic shift, clamp
  always_comb begin
    sum     = EXT_W'(x) + RND;
    shifted = sum >>> SHIFT;
    if (shifted > SAT_MAX) begin
      y = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      y = SAT_MIN[DATA_W-1:0];
    end else begin
      y = shifted[DATA_W-1:0];
    end
  end
endmodule

// File: rtl/ifft_out_stage.sv
// Final radix-2 butterflies of a 4-point IFFT; scaled bins are held and
// streamed out one per beat with valid/ready flow control.
module ifft_out_stage #(
  parameter int SHIFT  = 2,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] y0_re,
  input  logic signed [DATA_W-1:0] y0_im,
  input  logic signed [DATA_W-1:0] y1_re,
  input  logic signed [DATA_W-1:0] y1_im,
  input  logic signed [DATA_W-1:0] y2_re,
  input  logic signed [DATA_W-1:0] y2_im,
  input  logic signed [DATA_W-1:0] y3_re,
  input  logic signed [DATA_W-1:0] y3_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [1:0]               out_idx,
  output logic                     out_last,
  output logic                     busy
);
  import ifft_pkg::*;

  state_t state;
  state_t next_state;

  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         next_idx;
  logic signed [DATA_W:0]   x_re [N_PTS];
  logic signed [DATA_W:0]   x_im [N_PTS];
  logic signed [DATA_W-1:0] s_re [N_PTS];
  logic signed [DATA_W-1:0] s_im [N_PTS];
  logic signed [DATA_W-1:0] res_re [N_PTS];
  logic signed [DATA_W-1:0] res_im [N_PTS];
  logic                     last_beat;
  logic                     accept;
  logic                     advance;

  // butterflies, stored in output order X0, X1, X2, X3
  always_comb begin
    x_re[0] = (DATA_W+1)'(y0_re) + (DATA_W+1)'(y1_re);
    x_im[0] = (DATA_W+1)'(y0_im) + (DATA_W+1)'(y1_im);
    x_re[1] = (DATA_W+1)'(y2_re) + (DATA_W+1)'(y3_re);
    x_im[1] = (DATA_W+1)'(y2_im) + (DATA_W+1)'(y3_im);
    x_re[2] = (DATA_W+1)'(y0_re) - (DATA_W+1)'(y1_re);
    x_im[2] = (DATA_W+1)'(y0_im) - (DATA_W+1)'(y1_im);
    x_re[3] = (DATA_W+1)'(y2_re) - (DATA_W+1)'(y3_re);
    x_im[3] = (DATA_W+1)'(y2_im) - (DATA_W+1)'(y3_im);
  end

  for (genvar k = 0; k < N_PTS; k++) begin : g_scale
    ifft_round_sat #(.DATA_W(DATA_W), .SHIFT(SHIFT)) u_re (.x(x_re[k]), .y(s_re[k]));
    ifft_round_sat #(.DATA_W(DATA_W), .SHIFT(SHIFT)) u_im (.x(x_im[k]), .y(s_im[k]));
  end

  assign last_beat = (idx == IDX_W'(N_PTS - 1));
  assign next_idx  = idx + IDX_W'(1);
  assign in_ready  = (state == IDLE) || (last_beat && out_ready);
  assign accept    = in_valid && in_ready;
  assign advance   = (state == DRAIN) && out_ready;
  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign out_idx   = idx;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next state; a new frame accepted on the last beat keeps DRAIN with no bubble
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = DRAIN;
        else        next_state = IDLE;
      end
      DRAIN: begin
        if (advance && last_beat && !accept) next_state = IDLE;
        else                                 next_state = DRAIN;
      end
      default: next_state = IDLE;
    endcase
  end

  // result hold registers and the registered output beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      out_re   <= '0;
      out_im   <= '0;
      out_last <= 1'b0;
      for (int k = 0; k < N_PTS; k++) begin
        res_re[k] <= '0;
        res_im[k] <= '0;
      end
    end else if (accept) begin
      idx      <= '0;
      out_re   <= s_re[0];
      out_im   <= s_im[0];
      out_last <= 1'b0;
      for (int k = 0; k < N_PTS; k++) begin
        res_re[k] <= s_re[k];
        res_im[k] <= s_im[k];
      end
    end else if (advance) begin
      idx      <= next_idx;
      out_re   <= res_re[next_idx];
      out_im   <= res_im[next_idx];
      out_last <= (next_idx == IDX_W'(N_PTS - 1));
    end
  end
endmodule

// File: tb/tb_ifft_out_stage.sv
// Randomized and directed bench for ifft_out_stage; instance 0 uses SHIFT=2, instance 1 SHIFT=0.
module tb_ifft_out_stage;
  localparam int DW = 16;

  typedef struct {
    int re;
    int im;
    int idx;
    bit last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic out_ready;
  logic signed [DW-1:0] y_re [4];
  logic signed [DW-1:0] y_im [4];
  logic                 in_ready  [2];
  logic                 out_valid [2];
  logic signed [DW-1:0] out_re    [2];
  logic signed [DW-1:0] out_im    [2];
  logic [1:0]           out_idx   [2];
  logic                 out_last  [2];
  logic                 busy      [2];

  int n_checks = 0;
  int n_fail   = 0;
  beat_t exp_q [2][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ifft_out_stage #(.SHIFT(g == 0 ? 2 : 0), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[g]),
      .y0_re(y_re[0]), .y0_im(y_im[0]), .y1_re(y_re[1]), .y1_im(y_im[1]),
      .y2_re(y_re[2]), .y2_im(y_im[2]), .y3_re(y_re[3]), .y3_im(y_im[3]),
      .out_valid(out_valid[g]), .out_ready(out_ready), .out_re(out_re[g]),
      .out_im(out_im[g]), .out_idx(out_idx[g]), .out_last(out_last[g]), .busy(busy[g])
    );
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: butterfly in exact integers, round half up, floor shift, clamp.
  function automatic int bin_val(input int a, input int b, input bit sub, input int sh);
    int x;
    x = sub ? (a - b) : (a + b);
    x = (x + ((1 << sh) >> 1)) >>> sh;
    if (x > 32767) x = 32767;
    if (x < -32768) x = -32768;
    return x;
  endfunction

  // Protocol monitor: expected queue of beats drives valid/ready/data expectations.
  always @(negedge clk) begin : mon
    bit    has_beat;
    bit    exp_rdy;
    beat_t b;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        exp_q[d].delete();
        check("rst_valid", out_valid[d], 0);
        check("rst_re", out_re[d], 0);
        check("rst_im", out_im[d], 0);
        check("rst_idx", out_idx[d], 0);
        check("rst_last", out_last[d], 0);
        check("rst_busy", busy[d], 0);
        check("rst_in_ready", in_ready[d], 1);
      end else begin
        has_beat = (exp_q[d].size() > 0);
        exp_rdy  = !has_beat || (exp_q[d].size() == 1 && out_ready);
        check("mon_in_ready", in_ready[d], exp_rdy);
        check("mon_valid", out_valid[d], has_beat);
        check("mon_busy", busy[d], has_beat);
        if (has_beat) begin
          check("mon_re", out_re[d], exp_q[d][0].re);
          check("mon_im", out_im[d], exp_q[d][0].im);
          check("mon_idx", out_idx[d], exp_q[d][0].idx);
          check("mon_last", out_last[d], exp_q[d][0].last);
          if (out_ready) void'(exp_q[d].pop_front());
        end
        if (in_valid && exp_rdy) begin
          for (int i = 0; i < 4; i++) begin
            b.re   = bin_val(int'(y_re[2*(i%2)]), int'(y_re[2*(i%2)+1]), i >= 2, d == 0 ? 2 : 0);
            b.im   = bin_val(int'(y_im[2*(i%2)]), int'(y_im[2*(i%2)+1]), i >= 2, d == 0 ? 2 : 0);
            b.idx  = i;
            b.last = (i == 3);
            exp_q[d].push_back(b);
          end
        end
      end
    end
  end

  task automatic load(input int v[8]);
    for (int k = 0; k < 4; k++) begin
      y_re[k] = DW'(v[2*k]);
      y_im[k] = DW'(v[2*k+1]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise in_valid and hold the data until the DUT takes it (bounded).
  task automatic wait_accept(input bit keep, input bit rnd);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    while (!done && n < 64) begin
      @(negedge clk);
      done = in_ready[0];
      n++;
      step();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    if (!keep) in_valid = 1'b0;
    check("accept_seen", done, 1);
  endtask

  task automatic expect_frame(input int d, input int e[8]);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("dir_valid", out_valid[d], 1);
      check("dir_re", out_re[d], e[2*b]);
      check("dir_im", out_im[d], e[2*b+1]);
      check("dir_idx", out_idx[d], b);
      check("dir_last", out_last[d], b == 3);
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int at;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    load('{0, 0, 0, 0, 0, 0, 0, 0});
    repeat (3) step();
    reset = 1'b0;
    step();

    // basic frame with one-cycle latency
    load('{100, 0, 20, 0, 8, 4, -4, 4});
    wait_accept(1'b0, 1'b0);
    expect_frame(0, '{30, 0, 1, 2, 20, 0, 3, 0});
    step();

    // negative rounding
    load('{-3, 0, -3, 0, 0, 0, 0, 0});
    wait_accept(1'b0, 1'b0);
    expect_frame(0, '{-1, 0, 0, 0, 0, 0, 0, 0});

    // saturation at SHIFT=0
    load('{32767, -32768, 1, -1, 0, 0, 0, 0});
    wait_accept(1'b0, 1'b0);
    expect_frame(1, '{32767, -32768, 0, 0, 32766, -32767, 0, 0});
    step();

    // backpressure during beat 1
    load('{1000, -500, 300, 200, -700, 90, 60, -80});
    wait_accept(1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_idx", out_idx[0], 1);
      check("bp_in_ready", in_ready[0], 0);
      step();
    end
    out_ready = 1'b1;
    repeat (5) step();

    // back-to-back frames
    load('{400, 40, -400, 4, 12, -12, 7, 9});
    wait_accept(1'b1, 1'b0);
    load('{-900, 800, 33, -33, 1, 2, 3, 4});
    cnt = 0;
    at = -1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        cnt++;
        at = out_idx[0];
      end
      step();
    end
    in_valid = 1'b0;
    check("b2b_ready_count", cnt, 1);
    check("b2b_ready_idx", at, 3);
    repeat (5) step();

    // reset during beat 2
    load('{5000, 5000, -5000, 100, 64, -64, 32, 16});
    wait_accept(1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
    #1;
    check("midrst_valid", out_valid[0], 0);
    check("midrst_idx", out_idx[0], 0);
    check("midrst_in_ready", in_ready[0], 1);
    step();
    reset = 1'b0;
    step();
    load('{100, 0, 20, 0, 8, 4, -4, 4});
    wait_accept(1'b0, 1'b0);
    expect_frame(0, '{30, 0, 1, 2, 20, 0, 3, 0});

    // randomized frames with random backpressure and gaps
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) y_re[k] = ($urandom_range(0, 1) != 0) ? 16'sh7FFF : 16'sh8000;
        else y_re[k] = DW'($urandom);
        if ($urandom_range(0, 3) == 0) y_im[k] = ($urandom_range(0, 1) != 0) ? 16'sh7FFF : 16'sh8000;
        else y_im[k] = DW'($urandom);
      end
      wait_accept(1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        step();
        out_ready = 1'($urandom_range(0, 1));
      end
    end

    out_ready = 1'b1;
    repeat (10) step();
    check("drain_empty0", exp_q[0].size(), 0);
    check("drain_empty1", exp_q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
